// File: rtl/fft_seq_ctrl.sv
// Phase sequencer for the in-place radix-2 FFT: PREPARE, then CORE/WAIT/ARRANGE once per stage, then FLUSH.
// FFT size and WAIT length are latched per run; start/busy/done handshake with abort and config-error pulse.
module fft_seq_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_LOG2N  = 12,
  parameter int WAIT_WIDTH = 4,
  parameter int ARR_EXTRA  = 2,
  parameter int END_DELAY  = 10,
  parameter int NUM_WE     = 6,
  parameter logic [NUM_WE-1:0] WE_LOAD = 6'b011011,
  parameter logic [NUM_WE-1:0] WE_CORE = 6'b100100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            log2n,
  input  logic [WAIT_WIDTH-1:0] wait_cycles,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  ena_prepare,
  output logic                  ena_fft_core,
  output logic                  ena_fft_wait,
  output logic                  ena_arrange,
  output logic [3:0]            stage_level,
  output logic [3:0]            stage_number,
  output logic [ADDR_WIDTH-1:0] max_point_fft,
  output logic [ADDR_WIDTH-1:0] max_point_core,
  output logic [NUM_WE-1:0]     wr_ena
);

  // One extra bit so N = 2**ADDR_WIDTH plus the ARRANGE drain still fits.
  localparam int CW0 = ADDR_WIDTH + 1;
  localparam int CW1 = (WAIT_WIDTH > CW0) ? WAIT_WIDTH : CW0;
  localparam int CWD = $clog2(END_DELAY + 1);
  localparam int CW  = (CWD > CW1) ? CWD : CW1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREPARE, S_CORE, S_WAIT, S_ARRANGE, S_FLUSH
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         n_pts;
  logic [WAIT_WIDTH-1:0] wait_q;
  logic                  cfg_ok, accept, reject, stage_adv, last_stage, done_next;
  logic [NUM_WE-1:0]     we_next;

  assign cfg_ok     = (log2n != 4'd0) && (int'(log2n) <= MAX_LOG2N);
  assign last_stage = (stage_level == stage_number - 4'd1);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    stage_adv  = 1'b0;
    done_next  = 1'b0;
    we_next    = '0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            accept     = 1'b1;
            state_next = S_PREPARE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_PREPARE: begin
        we_next = WE_LOAD;
        if (cnt == n_pts - CW'(1)) state_next = S_CORE;
      end
      S_CORE: begin
        we_next = WE_CORE;
        if (cnt == (n_pts >> 1) - CW'(1)) state_next = S_WAIT;
      end
      S_WAIT: begin
        we_next = WE_CORE;
        if (cnt == CW'(wait_q)) state_next = S_ARRANGE;
      end
      S_ARRANGE: begin
        we_next = WE_LOAD;
        if (cnt == n_pts + CW'(ARR_EXTRA - 1)) begin
          stage_adv  = 1'b1;
          state_next = last_stage ? S_FLUSH : S_CORE;
        end
      end
      S_FLUSH: begin
        if (cnt == CW'(END_DELAY - 1)) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides every phase transition and suppresses the done pulse.
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
      stage_adv  = 1'b0;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      stage_level    <= '0;
      stage_number   <= '0;
      max_point_fft  <= '0;
      max_point_core <= '0;
      wr_ena         <= '0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      cnt     <= (state == S_IDLE || state_next != state) ? '0 : cnt + CW'(1);
      wr_ena  <= we_next;
      done    <= done_next;
      cfg_err <= reject;
      if (accept) begin
        stage_level    <= '0;
        stage_number   <= log2n;
        max_point_fft  <= ADDR_WIDTH'((CW'(1) << log2n) - CW'(1));
        max_point_core <= ADDR_WIDTH'((CW'(1) << (log2n - 4'd1)) - CW'(1));
      end else if (abort && state != S_IDLE) begin
        stage_level <= '0;
      end else if (stage_adv) begin
        stage_level <= last_stage ? 4'd0 : stage_level + 4'd1;
      end
    end
  end

  // Run configuration only matters once a start has been accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      n_pts  <= CW'(1) << log2n;
      wait_q <= wait_cycles;
    end
  end

  assign busy         = (state != S_IDLE);
  assign ena_prepare  = (state == S_PREPARE);
  assign ena_fft_core = (state == S_CORE);
  assign ena_fft_wait = (state == S_WAIT);
  assign ena_arrange  = (state == S_ARRANGE);

endmodule
